// File: rtl/ins_dispatcher.sv
// Fetches a block of instructions from BRAM and issues them one at a time to the controller.
// Issue waits on ctrl_busy without limit. A watchdog bounds each wait for ctrl_valid.
module ins_dispatcher #(
  parameter int ADDR_W  = 10,
  parameter int INS_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   issued_o,
  output logic              imem_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INS_W-1:0]  imem_rdata_i,
  output logic              ctrl_en_o,
  output logic [INS_W-1:0]  ctrl_ins_o,
  input  logic              ctrl_busy_i,
  input  logic              ctrl_valid_i
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] ISSUE_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W:0]   issued;
  logic [INS_W-1:0]  ins_q;
  logic [WD_W-1:0]   wdog;
  logic              err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      ptr    <= '0;
      rem    <= '0;
      issued <= '0;
      ins_q  <= '0;
      wdog   <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            ptr    <= base_addr_i;
            rem    <= count_i;
            err    <= 1'b0;
            issued <= '0;
            state  <= (count_i == '0) ? DONE : FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          ins_q <= imem_rdata_i;
          ptr   <= ptr + 1'b1;
          if (rem != '0) rem <= rem - 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          if (!ctrl_busy_i) begin
            if (issued != ISSUE_MAX) issued <= issued + 1'b1;
            wdog  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (ctrl_valid_i) begin
            state <= (rem != '0) ? FETCH : DONE;
          end else if (wdog == WD_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign err_o       = err;
  assign issued_o    = issued;
  assign imem_en_o   = (state == FETCH);
  assign imem_addr_o = ptr;
  assign ctrl_en_o   = (state == ISSUE) && !ctrl_busy_i;
  assign ctrl_ins_o  = ins_q;

endmodule
